// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch-resolution stage: branch opcodes, FSM states, widths.
package branch_resolve_pkg;

  parameter int unsigned DefaultDataW = 16;

  localparam logic [1:0] BR_BEQZ = 2'b00;
  localparam logic [1:0] BR_BNEZ = 2'b01;
  localparam logic [1:0] BR_BLTZ = 2'b10;
  localparam logic [1:0] BR_BGEZ = 2'b11;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StEval     = 2'b01,
    StRedirect = 2'b10
  } br_state_e;

endpackage

// File: rtl/branch_resolve_br_cond.sv
// Combinational zero/sign condition evaluator; shared with the set-condition path.
module branch_resolve_br_cond
  import branch_resolve_pkg::*;
#(
  parameter int unsigned DataW = DefaultDataW
) (
  input  logic [1:0]       op_i,
  input  logic [DataW-1:0] val_i,
  output logic             taken_o
);

  logic is_zero;
  logic is_neg;

  assign is_zero = (val_i == '0);
  assign is_neg  = val_i[DataW-1];

  always_comb begin
    taken_o = 1'b0;
    unique case (op_i)
      BR_BEQZ: taken_o = is_zero;
      BR_BNEZ: taken_o = ~is_zero;
      BR_BLTZ: taken_o = is_neg;
      BR_BGEZ: taken_o = ~is_neg;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch-resolution stage: captures a branch, evaluates it, and holds a fetch redirect until acked.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned DataW = DefaultDataW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             br_valid_i,
  output logic             br_ready_o,
  input  logic [1:0]       br_op_i,
  input  logic [DataW-1:0] rs_val_i,
  input  logic [DataW-1:0] pc_plus2_i,
  input  logic [DataW-1:0] imm_i,
  input  logic             flush_i,
  output logic             resolved_o,
  output logic             taken_o,
  output logic             redirect_valid_o,
  output logic [DataW-1:0] redirect_pc_o,
  input  logic             redirect_ack_i,
  output logic [15:0]      taken_count_o
);

  br_state_e        state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [DataW-1:0] rs_q, rs_d;
  logic [DataW-1:0] tgt_q, tgt_d;
  logic             resolved_q, resolved_d;
  logic             taken_q, taken_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             cond_taken;

  branch_resolve_br_cond #(
    .DataW (DataW)
  ) u_br_cond (
    .op_i    (op_q),
    .val_i   (rs_q),
    .taken_o (cond_taken)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rs_d       = rs_q;
    tgt_d      = tgt_q;
    resolved_d = 1'b0;
    taken_d    = 1'b0;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (br_valid_i && !flush_i) begin
          op_d    = br_op_i;
          rs_d    = rs_val_i;
          tgt_d   = pc_plus2_i + imm_i;
          state_d = StEval;
        end
      end
      StEval: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          resolved_d = 1'b1;
          taken_d    = cond_taken;
          state_d    = cond_taken ? StRedirect : StIdle;
        end
      end
      StRedirect: begin
        // An ack coinciding with flush still counts: fetch already took the redirect.
        if (redirect_ack_i) begin
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
          state_d = StIdle;
        end else if (flush_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      op_q       <= BR_BEQZ;
      rs_q       <= '0;
      tgt_q      <= '0;
      resolved_q <= 1'b0;
      taken_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rs_q       <= rs_d;
      tgt_q      <= tgt_d;
      resolved_q <= resolved_d;
      taken_q    <= taken_d;
      cnt_q      <= cnt_d;
    end
  end

  assign br_ready_o       = (state_q == StIdle);
  assign redirect_valid_o = (state_q == StRedirect);
  assign redirect_pc_o    = tgt_q;
  assign resolved_o       = resolved_q;
  assign taken_o          = taken_q;
  assign taken_count_o    = cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        br_valid_i;
  logic        br_ready_o;
  logic [1:0]  br_op_i;
  logic [15:0] rs_val_i;
  logic [15:0] pc_plus2_i;
  logic [15:0] imm_i;
  logic        flush_i;
  logic        resolved_o;
  logic        taken_o;
  logic        redirect_valid_o;
  logic [15:0] redirect_pc_o;
  logic        redirect_ack_i;
  logic [15:0] taken_count_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [15:0] exp_cnt;

  always #5 clk_i = ~clk_i;

  branch_resolve #(
    .DataW (16)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .br_valid_i       (br_valid_i),
    .br_ready_o       (br_ready_o),
    .br_op_i          (br_op_i),
    .rs_val_i         (rs_val_i),
    .pc_plus2_i       (pc_plus2_i),
    .imm_i            (imm_i),
    .flush_i          (flush_i),
    .resolved_o       (resolved_o),
    .taken_o          (taken_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ack_i   (redirect_ack_i),
    .taken_count_o    (taken_count_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the EVAL cycle.
  task automatic start_branch(input string tag, input logic [1:0] op, input logic [15:0] rs,
                              input logic [15:0] pc, input logic [15:0] imm);
    check_eq({tag, ".idle_ready"}, 32'(br_ready_o), 32'd1);
    br_valid_i = 1'b1;
    br_op_i    = op;
    rs_val_i   = rs;
    pc_plus2_i = pc;
    imm_i      = imm;
    @(negedge clk_i);
    br_valid_i = 1'b0;
    rs_val_i   = ~rs;
    pc_plus2_i = ~pc;
    check_eq({tag, ".eval_ready"}, 32'(br_ready_o), 32'd0);
    check_eq({tag, ".eval_resolved"}, 32'(resolved_o), 32'd0);
  endtask

  task automatic run_branch(input string tag, input logic [1:0] op, input logic [15:0] rs,
                            input logic [15:0] pc, input logic [15:0] imm, input logic exp_tk,
                            input logic [15:0] exp_pc, input int hold);
    start_branch(tag, op, rs, pc, imm);
    @(negedge clk_i);
    check_eq({tag, ".resolved"}, 32'(resolved_o), 32'd1);
    check_eq({tag, ".taken"}, 32'(taken_o), 32'(exp_tk));
    check_eq({tag, ".rd_valid"}, 32'(redirect_valid_o), 32'(exp_tk));
    check_eq({tag, ".ready"}, 32'(br_ready_o), 32'(!exp_tk));
    if (exp_tk) begin
      check_eq({tag, ".rd_pc"}, 32'(redirect_pc_o), 32'(exp_pc));
      for (int c = 0; c < hold; c++) begin
        br_valid_i = 1'b1;
        br_op_i    = ~op;
        rs_val_i   = ~rs;
        pc_plus2_i = 16'h5555;
        imm_i      = 16'h0002;
        @(negedge clk_i);
        check_eq($sformatf("%s.hold%0d_valid", tag, c), 32'(redirect_valid_o), 32'd1);
        check_eq($sformatf("%s.hold%0d_pc", tag, c), 32'(redirect_pc_o), 32'(exp_pc));
        check_eq($sformatf("%s.hold%0d_ready", tag, c), 32'(br_ready_o), 32'd0);
      end
      br_valid_i     = 1'b0;
      redirect_ack_i = 1'b1;
      @(negedge clk_i);
      redirect_ack_i = 1'b0;
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      check_eq({tag, ".post_valid"}, 32'(redirect_valid_o), 32'd0);
      check_eq({tag, ".post_ready"}, 32'(br_ready_o), 32'd1);
      check_eq({tag, ".count"}, 32'(taken_count_o), 32'(exp_cnt));
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] rs;
    logic [15:0] pc;
    logic [15:0] imm;
    logic        tk;
    logic [15:0] tgt;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{BR_BEQZ, 16'h0000, 16'h0100, 16'h0010, 1'b1, 16'h0110};
    vecs[1] = '{BR_BNEZ, 16'h0000, 16'h0100, 16'h0010, 1'b0, 16'h0000};
    vecs[2] = '{BR_BLTZ, 16'h8000, 16'hFFFE, 16'h0004, 1'b1, 16'h0002};
    vecs[3] = '{BR_BGEZ, 16'h8000, 16'h0200, 16'h0008, 1'b0, 16'h0000};
    vecs[4] = '{BR_BGEZ, 16'h7FFF, 16'h0002, 16'hFFF8, 1'b1, 16'hFFFA};
    vecs[5] = '{BR_BNEZ, 16'h0001, 16'h1000, 16'h0020, 1'b1, 16'h1020};
    vecs[6] = '{BR_BLTZ, 16'h7FFF, 16'h1000, 16'h0020, 1'b0, 16'h0000};
    vecs[7] = '{BR_BEQZ, 16'h0001, 16'h1000, 16'h0020, 1'b0, 16'h0000};

    rst_ni         = 1'b0;
    br_valid_i     = 1'b0;
    br_op_i        = BR_BEQZ;
    rs_val_i       = '0;
    pc_plus2_i     = '0;
    imm_i          = '0;
    flush_i        = 1'b0;
    redirect_ack_i = 1'b0;
    exp_cnt        = 16'h0000;

    #12;
    check_eq("rst.ready", 32'(br_ready_o), 32'd1);
    check_eq("rst.resolved", 32'(resolved_o), 32'd0);
    check_eq("rst.taken", 32'(taken_o), 32'd0);
    check_eq("rst.rd_valid", 32'(redirect_valid_o), 32'd0);
    check_eq("rst.rd_pc", 32'(redirect_pc_o), 32'h0000);
    check_eq("rst.count", 32'(taken_count_o), 32'h0000);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 8; i++) begin
      run_branch($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].pc, vecs[i].imm,
                 vecs[i].tk, vecs[i].tgt, 0);
    end

    run_branch("hold", BR_BNEZ, 16'h1234, 16'h2000, 16'h0100, 1'b1, 16'h2100, 5);

    // Flush during EVAL of a branch that would be taken.
    start_branch("fl_eval", BR_BEQZ, 16'h0000, 16'h0400, 16'h0004);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check_eq("fl_eval.resolved", 32'(resolved_o), 32'd0);
    check_eq("fl_eval.rd_valid", 32'(redirect_valid_o), 32'd0);
    check_eq("fl_eval.ready", 32'(br_ready_o), 32'd1);
    check_eq("fl_eval.count", 32'(taken_count_o), 32'(exp_cnt));

    // Flush without ack in REDIRECT.
    start_branch("fl_rd", BR_BLTZ, 16'hFFFF, 16'h0500, 16'h0006);
    @(negedge clk_i);
    check_eq("fl_rd.rd_valid", 32'(redirect_valid_o), 32'd1);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check_eq("fl_rd.post_valid", 32'(redirect_valid_o), 32'd0);
    check_eq("fl_rd.ready", 32'(br_ready_o), 32'd1);
    check_eq("fl_rd.count", 32'(taken_count_o), 32'(exp_cnt));

    // Flush and ack together in REDIRECT: delivered.
    start_branch("fl_ack", BR_BGEZ, 16'h0000, 16'h0600, 16'h0002);
    @(negedge clk_i);
    flush_i        = 1'b1;
    redirect_ack_i = 1'b1;
    @(negedge clk_i);
    flush_i        = 1'b0;
    redirect_ack_i = 1'b0;
    exp_cnt        = exp_cnt + 16'd1;
    check_eq("fl_ack.post_valid", 32'(redirect_valid_o), 32'd0);
    check_eq("fl_ack.ready", 32'(br_ready_o), 32'd1);
    check_eq("fl_ack.count", 32'(taken_count_o), 32'h0006);

    // br_valid with flush in IDLE is ignored.
    br_valid_i = 1'b1;
    flush_i    = 1'b1;
    br_op_i    = BR_BEQZ;
    rs_val_i   = 16'h0000;
    @(negedge clk_i);
    br_valid_i = 1'b0;
    flush_i    = 1'b0;
    check_eq("vf_idle.ready", 32'(br_ready_o), 32'd1);
    @(negedge clk_i);
    check_eq("vf_idle.resolved", 32'(resolved_o), 32'd0);
    check_eq("vf_idle.rd_valid", 32'(redirect_valid_o), 32'd0);

    // Asynchronous reset while a redirect is pending.
    start_branch("rst_rd", BR_BEQZ, 16'h0000, 16'h0300, 16'h0004);
    @(negedge clk_i);
    check_eq("rst_rd.pre_valid", 32'(redirect_valid_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("rst_rd.rd_valid", 32'(redirect_valid_o), 32'd0);
    check_eq("rst_rd.count", 32'(taken_count_o), 32'h0000);
    check_eq("rst_rd.ready", 32'(br_ready_o), 32'd1);
    check_eq("rst_rd.resolved", 32'(resolved_o), 32'd0);
    check_eq("rst_rd.rd_pc", 32'(redirect_pc_o), 32'h0000);
    @(negedge clk_i);
    rst_ni  = 1'b1;
    exp_cnt = 16'h0000;
    @(negedge clk_i);
    check_eq("rst_rd.after_valid", 32'(redirect_valid_o), 32'd0);

    // Saturation: preload the counter just below the ceiling.
    force dut.cnt_q = 16'hFFFE;
    @(negedge clk_i);
    release dut.cnt_q;
    @(negedge clk_i);
    exp_cnt = 16'hFFFE;
    check_eq("sat.preload", 32'(taken_count_o), 32'h0000FFFE);
    run_branch("sat1", BR_BEQZ, 16'h0000, 16'h0010, 16'h0010, 1'b1, 16'h0020, 0);
    check_eq("sat1.value", 32'(taken_count_o), 32'h0000FFFF);
    run_branch("sat2", BR_BEQZ, 16'h0000, 16'h0010, 16'h0010, 1'b1, 16'h0020, 0);
    check_eq("sat2.value", 32'(taken_count_o), 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Sequential branch-resolution stage for the 16-bit processor datapath. It accepts a conditional branch (opcode class, register operand, PC+2, sign-extended offset), evaluates the zero/sign condition of the register operand, and computes the target. On a taken branch it holds a redirect request to fetch until fetch acknowledges it. It is the consumer side of the condition logic: it reads a register value and decides control flow, where the set-condition logic turns ALU flags into a register value.

## Interface

- DATA_W, 16, datapath, PC and offset width
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- br_valid  input  1  branch request present
- br_ready  output  1  stage can accept a request (high only in IDLE)
- br_op  input  2  00 BEQZ, 01 BNEZ, 10 BLTZ, 11 BGEZ
- rs_val  input  DATA_W  register operand under test
- pc_plus2  input  DATA_W  address of the following instruction
- imm  input  DATA_W  sign-extended byte offset
- flush  input  1  squash any in-flight branch (older-instruction exception)
- resolved  output  1  one-cycle pulse: branch outcome known
- taken  output  1  outcome, valid while resolved=1
- redirect_valid  output  1  fetch redirect requested
- redirect_pc  output  DATA_W  redirect target, stable while redirect_valid=1
- redirect_ack  input  1  fetch accepted redirect
- taken_count  output  16  saturating count of delivered redirects

## Operation

- States: IDLE, EVAL, REDIRECT.
- IDLE: br_ready=1. br_valid=1 and flush=0 capture br_op, rs_val, and target=pc_plus2+imm (modulo 2^16, carry discarded), then go to EVAL. br_valid=1 with flush=1 is ignored.
- EVAL: evaluate the condition on the captured operand.
  - BEQZ: rs==0.
  - BNEZ: rs!=0.
  - BLTZ: rs[15]=1.
  - BGEZ: rs[15]=0.
  - Pulse resolved and drive taken. Taken goes to REDIRECT. Not taken goes to IDLE.
  - flush in EVAL: go to IDLE, with no resolved pulse and no redirect.
- REDIRECT: redirect_valid=1, redirect_pc=captured target.
  - redirect_ack=1 goes to IDLE and increments taken_count, saturating at 0xFFFF.
  - flush without ack goes to IDLE with no increment.
  - flush and ack in the same cycle: the redirect counts as delivered (count increments) and the state goes to IDLE.
- Captured registers do not change outside IDLE. Input changes during EVAL or REDIRECT have no effect.
- Reset, asynchronous and applicable at any cycle including mid-redirect:
  - state=IDLE.
  - br_ready=1.
  - resolved=0, taken=0.
  - redirect_valid=0, redirect_pc=0x0000.
  - taken_count=0x0000.
  - No pending redirect survives reset.

## Timing

- Request accepted at edge N, when br_valid and br_ready are both high. EVAL runs in cycle N+1. resolved and taken are registered and visible in cycle N+2.
- Not taken: br_ready=1 again in cycle N+2, so back-to-back not-taken branches sustain one branch per 2 cycles.
- Taken: redirect_valid asserts in cycle N+2 together with resolved. It holds for as many cycles as it takes to see redirect_ack. With ack in cycle N+2, br_ready=1 in cycle N+3.
- All outputs are registered, with no combinational input-to-output paths. redirect_ack is sampled only in REDIRECT.

## Structure

- Shared package:
  - br_op encoding constants (BR_BEQZ, BR_BNEZ, BR_BLTZ, BR_BGEZ).
  - FSM state encoding.
  - DATA_W default.
- Sub-module br_cond: combinational condition evaluator (op, operand → taken). Instantiated once, in the EVAL path. Reusable by the set-condition path.
- Top level: FSM, capture registers, target adder, saturating counter.

## Test plan

- Reset mid-REDIRECT: assert rst_n=0 while redirect_valid=1 → the same cycle shows redirect_valid=0, taken_count=0, br_ready=1.
- Condition sweep:
  - BEQZ rs=0x0000 is taken; BNEZ rs=0x0000 is not taken.
  - BLTZ rs=0x8000 is taken; BGEZ rs=0x8000 is not taken.
  - BGEZ rs=0x7FFF is taken.
  - Each resolved pulse appears exactly 2 cycles after acceptance.
- Target wrap-around:
  - pc_plus2=0xFFFE, imm=0x0004 → redirect_pc=0x0002.
  - pc_plus2=0x0002, imm=0xFFF8 → redirect_pc=0xFFFA.
- Held redirect: taken branch with redirect_ack held low 5 cycles → redirect_valid and redirect_pc stable for all 5, br_ready=0. Ack → IDLE next cycle, taken_count +1.
- Flush cases:
  - flush in EVAL → no resolved pulse, no redirect.
  - flush and ack together in REDIRECT → taken_count increments, state IDLE.
  - br_valid together with flush in IDLE → not accepted.
- Saturation: force 0xFFFF delivered redirects (or preload via bench) → one more ack leaves taken_count=0xFFFF.
